// File: rtl/fifo_pack_if.sv
// fifo_pack_if: FIFO read port plus packed valid/ready output stream of fifo_pack.
// slave is the fifo_pack side; master is the FIFO/consumer side.
interface fifo_pack_if #(
  parameter int WIDTH = 16,
  parameter int RATIO = 4
);
  localparam int CW = $clog2(RATIO) + 1;

  logic [WIDTH-1:0]       fifo_rdata;
  logic                   fifo_rempty;
  logic                   fifo_rpop;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH*RATIO-1:0] out_data;
  logic [CW-1:0]          out_cnt;
  logic                   out_last;

  modport slave (
    input  fifo_rdata, fifo_rempty, flush, out_ready,
    output fifo_rpop, out_valid, out_data, out_cnt, out_last
  );

  modport master (
    output fifo_rdata, fifo_rempty, flush, out_ready,
    input  fifo_rpop, out_valid, out_data, out_cnt, out_last
  );
endinterface

// File: rtl/fifo_pack.sv
// fifo_pack: drains a FIFO with one-cycle read latency, packing RATIO words per output beat.
// Define FIFO_PACK_FLUSH_EN to compile in the partial-beat flush.
module fifo_pack #(
  parameter int WIDTH = 16,
  parameter int RATIO = 4
) (
  input  logic       clk,
  input  logic       rst,
  fifo_pack_if.slave bus
);
  localparam int CW = $clog2(RATIO) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RATIO);

  logic [RATIO-1:0][WIDTH-1:0] acc_r;
  logic [RATIO-1:0][WIDTH-1:0] acc_cap_s;
  logic [CW-1:0]               acc_cnt_r;
  logic [CW-1:0]               sum_s;
  logic                        pop_d_r;
  logic                        flush_pend_s;
  logic                        slot_free_s;
  logic                        beat_go_s;
  logic                        out_valid_r;
  logic [WIDTH*RATIO-1:0]      out_data_r;
  logic [CW-1:0]               out_cnt_r;
  logic                        out_last_r;

  // A word in flight already owns a slot, so it counts against the credit.
  assign sum_s        = acc_cnt_r + {{(CW-1){1'b0}}, pop_d_r};
  assign slot_free_s  = !out_valid_r | bus.out_ready;
  assign beat_go_s    = (sum_s == FULL_CNT) & slot_free_s;
  assign bus.fifo_rpop = !rst & !bus.fifo_rempty & !flush_pend_s & (sum_s < FULL_CNT);

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_cnt   = out_cnt_r;
  assign bus.out_last  = out_last_r;

  // Accumulator image including this cycle's returning word.
  always_comb begin
    acc_cap_s = acc_r;
    if (pop_d_r) begin
      acc_cap_s[acc_cnt_r[CW-2:0]] = bus.fifo_rdata;
    end else begin
      acc_cap_s = acc_r;
    end
  end

`ifdef FIFO_PACK_FLUSH_EN
  logic                        flush_pend_r;
  logic                        flush_go_s;
  logic [RATIO-1:0][WIDTH-1:0] pad_s;

  assign flush_pend_s = flush_pend_r;
  assign flush_go_s   = flush_pend_r & !pop_d_r & slot_free_s;

  // Zero words at and above acc_cnt so a partial beat never carries stale data.
  always_comb begin
    pad_s = {(RATIO*WIDTH){1'b0}};
    for (int i = 0; i < RATIO; i++) begin
      if (CW'(i) < acc_cnt_r) begin
        pad_s[i] = acc_r[i];
      end else begin
        pad_s[i] = {WIDTH{1'b0}};
      end
    end
  end

  // Flush request latch; a second request while pending is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend_r <= 1'b0;
    end else if (flush_go_s) begin
      flush_pend_r <= 1'b0;
    end else if (bus.flush) begin
      flush_pend_r <= 1'b1;
    end else begin
      flush_pend_r <= flush_pend_r;
    end
  end
`else
  logic flush_unused;
  assign flush_pend_s = 1'b0;
  assign flush_unused = bus.flush;
`endif

  // Word capture, beat hand-off to the output register and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_d_r     <= 1'b0;
      acc_r       <= {(RATIO*WIDTH){1'b0}};
      acc_cnt_r   <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {(RATIO*WIDTH){1'b0}};
      out_cnt_r   <= {CW{1'b0}};
      out_last_r  <= 1'b0;
    end else begin
      pop_d_r   <= bus.fifo_rpop;
      acc_r     <= acc_cap_s;
      acc_cnt_r <= sum_s;
      if (out_valid_r & bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
      if (beat_go_s) begin
        acc_cnt_r   <= {CW{1'b0}};
        out_valid_r <= 1'b1;
        out_data_r  <= acc_cap_s;
        out_cnt_r   <= FULL_CNT;
        out_last_r  <= 1'b0;
      end
`ifdef FIFO_PACK_FLUSH_EN
      // Covers both partial and full accumulators; an empty one emits nothing.
      if (flush_go_s && (acc_cnt_r != {CW{1'b0}})) begin
        acc_cnt_r   <= {CW{1'b0}};
        out_valid_r <= 1'b1;
        out_data_r  <= pad_s;
        out_cnt_r   <= acc_cnt_r;
        out_last_r  <= 1'b1;
      end
`endif
    end
  end
endmodule
